// File: rtl/efb_wb_arbiter_if.sv
// Wishbone bundle between two requesters, the arbiter and the EFB port.
// slave: arbiter view; master: environment (requesters + EFB) view.
interface efb_wb_arbiter_if #(
  parameter int ADR_W = 8,
  parameter int DAT_W = 8
);
  logic             m0_cyc;
  logic             m0_stb;
  logic             m0_we;
  logic [ADR_W-1:0] m0_adr;
  logic [DAT_W-1:0] m0_dat_w;
  logic [DAT_W-1:0] m0_dat_r;
  logic             m0_ack;
  logic             m0_err;

  logic             m1_cyc;
  logic             m1_stb;
  logic             m1_we;
  logic [ADR_W-1:0] m1_adr;
  logic [DAT_W-1:0] m1_dat_w;
  logic [DAT_W-1:0] m1_dat_r;
  logic             m1_ack;
  logic             m1_err;

  logic             s_cyc;
  logic             s_stb;
  logic             s_we;
  logic [ADR_W-1:0] s_adr;
  logic [DAT_W-1:0] s_dat_w;
  logic [DAT_W-1:0] s_dat_r;
  logic             s_ack;

  logic [1:0]       grant;

  modport slave (
    input  m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_w,
    output m0_dat_r, m0_ack, m0_err,
    input  m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_w,
    output m1_dat_r, m1_ack, m1_err,
    output s_cyc, s_stb, s_we, s_adr, s_dat_w,
    input  s_dat_r, s_ack,
    output grant
  );

  modport master (
    output m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_w,
    input  m0_dat_r, m0_ack, m0_err,
    output m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_w,
    input  m1_dat_r, m1_ack, m1_err,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_w,
    output s_dat_r, s_ack,
    input  grant
  );
endinterface

// File: rtl/efb_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter for the shared EFB port.
// Define EFB_WB_ARB_TIMEOUT_EN to build the stuck-grant watchdog.
module efb_wb_arbiter #(
  parameter int ADR_W          = 8,
  parameter int DAT_W          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             clock,
  input logic             reset_n,
  efb_wb_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  localparam logic [ADR_W-1:0] ADR_Z = '0;
  localparam logic [DAT_W-1:0] DAT_Z = '0;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last;
  logic       own0;
  logic       own1;
  logic       fire;
  logic [1:0] req;

  assign own0 = (state == GRANT0);
  assign own1 = (state == GRANT1);
  assign req  = {bus.m1_cyc, bus.m0_cyc};

`ifdef EFB_WB_ARB_TIMEOUT_EN
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;
  logic        stall;

  // Owner strobing with no ack; counted cycle LIMIT is the last one allowed.
  assign stall = ((own0 && bus.m0_stb) || (own1 && bus.m1_stb))
               && !bus.s_ack;
  assign fire  = stall && (cnt == LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (stall && !fire) begin
      cnt <= cnt + 16'd1;
    end else begin
      cnt <= '0;
    end
  end
`else
  assign fire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        unique case (1'b1)
          (req == 2'b11): state_nxt = last ? GRANT0 : GRANT1;
          (req == 2'b01): state_nxt = GRANT0;
          (req == 2'b10): state_nxt = GRANT1;
          default:        state_nxt = IDLE;
        endcase
      end
      GRANT0: if (!bus.m0_cyc || fire) state_nxt = IDLE;
      GRANT1: if (!bus.m1_cyc || fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE) begin
        last <= (state_nxt == GRANT1);
      end
    end
  end

  always_comb begin
    bus.s_cyc    = 1'b0;
    bus.s_stb    = 1'b0;
    bus.s_we     = 1'b0;
    bus.s_adr    = ADR_Z;
    bus.s_dat_w  = DAT_Z;
    bus.m0_ack   = 1'b0;
    bus.m0_err   = 1'b0;
    bus.m0_dat_r = DAT_Z;
    bus.m1_ack   = 1'b0;
    bus.m1_err   = 1'b0;
    bus.m1_dat_r = DAT_Z;
    unique case (1'b1)
      own0: begin
        bus.s_cyc    = bus.m0_cyc;
        bus.s_stb    = bus.m0_stb;
        bus.s_we     = bus.m0_we;
        bus.s_adr    = bus.m0_adr;
        bus.s_dat_w  = bus.m0_dat_w;
        bus.m0_ack   = bus.s_ack;
        bus.m0_dat_r = bus.s_dat_r;
        bus.m0_err   = fire;
      end
      own1: begin
        bus.s_cyc    = bus.m1_cyc;
        bus.s_stb    = bus.m1_stb;
        bus.s_we     = bus.m1_we;
        bus.s_adr    = bus.m1_adr;
        bus.s_dat_w  = bus.m1_dat_w;
        bus.m1_ack   = bus.s_ack;
        bus.m1_dat_r = bus.s_dat_r;
        bus.m1_err   = fire;
      end
      default: ;
    endcase
  end

  assign bus.grant = {own1, own0};

endmodule

// File: doc/efb_wb_arbiter.md
# efb_wb_arbiter

Two-master Wishbone arbiter that shares the single EFB Wishbone slave port (hard SPI master) between the ADC sampling path (master 0) and the storage/SD path (master 1). Grants are registered, round-robin on contention, and locked for the whole `cyc` window so multi-byte SPI transactions and their chip-select sequence are never interleaved. An optional bus watchdog releases a stuck grant. It sits between the requesting controllers and `efb` in the 84 MHz domain.

## Interface
Parameters:
- `ADR_W`, 8, Wishbone address width.
- `DAT_W`, 8, Wishbone data width.
- `TIMEOUT_CYCLES`, 255, clocks allowed from `stb` to `ack` before the watchdog fires (1..65535; counter is 16 bits).

Ports:
- `clock`  in  1  system clock (84 MHz domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `m0_cyc`, `m0_stb`, `m0_we`  in  1 each  master 0 cycle, strobe and write enable.
- `m0_adr`  in  ADR_W  master 0 address.
- `m0_dat_w`  in  DAT_W  master 0 write data.
- `m0_dat_r`  out  DAT_W  read data to master 0.
- `m0_ack`, `m0_err`  out  1 each  acknowledge and watchdog error to master 0.
- `m1_*`  same set as master 0, for master 1.
- `s_cyc`, `s_stb`, `s_we`  out  1 each  to the EFB.
- `s_adr`  out  ADR_W  to the EFB.
- `s_dat_w`  out  DAT_W  to the EFB.
- `s_dat_r`  in  DAT_W  from the EFB.
- `s_ack`  in  1  from the EFB.
- `grant`  out  2  one-hot current owner: bit n set means master n owns the slave; 2'b00 when idle.

## Operation
- States: IDLE, GRANT0, GRANT1. The state register also holds `last` (1 bit, last master granted).
- Reset: state=IDLE, `last`=1, so master 0 wins the first tie. All outputs are 0 while `reset_n`=0.
- IDLE: `s_*` are driven to 0.
  - Only `m0_cyc` high: go to GRANT0.
  - Only `m1_cyc` high: go to GRANT1.
  - Both high: grant the master ≠ `last`.
  - `last` is updated on entry to a GRANT state.
- GRANTn:
  - `s_cyc/s_stb/s_we/s_adr/s_dat_w` = `mn_*` (combinational mux selected by the registered state).
  - `mn_ack` = `s_ack`; `mn_dat_r` = `s_dat_r`.
  - The non-owner sees `ack`=0, `err`=0 and `dat_r`=0.
- Exit: `mn_cyc`=0 sampled in GRANTn returns to IDLE. This includes `cyc` dropping in the same cycle as the final `ack`.
- A request from the other master during GRANTn is held off. It is served from IDLE on the next cycle.
- Masters hold `cyc/stb/adr/we/dat_w` stable until `ack` (classic Wishbone). The arbiter does not register data.
- Reset asserted mid-transfer aborts immediately. `s_cyc` drops asynchronously and no `ack` is forwarded.

## Timing
- Grant latency: `mn_cyc` sampled high at edge k in IDLE gives GRANTn after edge k, with `s_cyc` high in cycle k+1.
- `ack` and read data pass combinationally to the owner (0-cycle added latency).
- Release: `cyc` low at edge j gives IDLE after j. There is at least one IDLE cycle between any two grants, including back-to-back grants to the same master.
- Watchdog (when enabled):
  - A 16-bit counter clears on grant entry, on `s_ack`, and whenever `s_stb`=0.
  - It increments each cycle in GRANTn with `s_stb`=1 and `s_ack`=0.
  - When the count reaches `TIMEOUT_CYCLES`, `mn_err` pulses for exactly 1 cycle and the state goes to IDLE on the same edge. `s_cyc` is therefore 0 the next cycle.
  - The master drops `cyc` on `err`.
  - If `s_ack` arrives in the same cycle as the count reaching `TIMEOUT_CYCLES`, `ack` wins, no `err` is raised and the counter clears.

## Configuration
- `EFB_WB_ARB_TIMEOUT_EN` defined:
  - The watchdog counter and `mn_err` logic are compiled in, as described under Timing.
- Not defined:
  - No counter is built.
  - `m0_err` and `m1_err` are tied to 0.
  - A grant is held until the owner drops `cyc`, regardless of `ack`.

## Test plan
- Reset: `reset_n`=0 with both `cyc` high → all outputs 0 and `grant`=00. Release → GRANT0 one cycle later, so master 0 wins the first tie.
- Single read: master 1 reads address 0x54 with the EFB `ack` after 3 cycles and `s_dat_r`=0xA5 → `m1_ack` in the same cycle with `m1_dat_r`=0xA5. `m0_ack` stays 0 throughout.
- Contention round-robin: both masters hold `cyc` for 4-transfer bursts, with `last`=0 → order is M1, M0, M1, each separated by one IDLE cycle. No transfer is interleaved inside a burst.
- Locked burst: master 0 keeps `cyc` high across 5 strobes while master 1 requests → `grant`=01 for all 5 `ack`s. Master 1 is granted 2 cycles after `m0_cyc` falls.
- Watchdog (macro defined, `TIMEOUT_CYCLES`=8): no `ack` → `m0_err` is a single pulse on the 8th stalled cycle, `s_cyc`=0 the next cycle, then `grant`=00. With `ack` on cycle 8 → `ack` only, no `err`.
- Macro undefined: the same stall for 1000 cycles → `grant` stays 01 and `err` stays 0.
